// File: rtl/graph_adj_responder_if.sv
// Load, request and response handshake bundle between the traversal engine (master)
// and the adjacency responder (slave).
interface graph_adj_responder_if #(
    parameter int NODE_W = 10,
    parameter int CNT_W  = 4
);
    logic              load_clear;
    logic              load_valid;
    logic              load_ready;
    logic [NODE_W-1:0] load_node;
    logic [NODE_W-1:0] load_succ;
    logic              load_err;
    logic              req_valid;
    logic              req_ready;
    logic [NODE_W-1:0] node_idx_reg;
    logic              resp_valid;
    logic              resp_ready;
    logic [NODE_W-1:0] next_node_idx;
    logic [CNT_W-1:0]  next_node_counter;
    logic              resp_last;

    modport master (
        output load_clear, load_valid, load_node, load_succ,
        output req_valid, node_idx_reg, resp_ready,
        input  load_ready, load_err, req_ready,
        input  resp_valid, next_node_idx, next_node_counter, resp_last
    );

    modport slave (
        input  load_clear, load_valid, load_node, load_succ,
        input  req_valid, node_idx_reg, resp_ready,
        output load_ready, load_err, req_ready,
        output resp_valid, next_node_idx, next_node_counter, resp_last
    );
endinterface

// File: rtl/graph_adj_responder.sv
// CSR adjacency store that streams a node's successors one per handshake.
// Define ADJ_STATS_EN to add the stat_edges / stat_max_fanout load statistics outputs.
module graph_adj_responder #(
    parameter int PARAM_NODE_IDX_WIDTH = 10,
    parameter int PARAM_COUNTER_WIDTH  = 4,
    parameter int PARAM_EDGE_MEM_DEPTH = 2048
) (
    input  logic clk,
    input  logic rst,
    graph_adj_responder_if.slave bus
`ifdef ADJ_STATS_EN
    ,
    output logic [$clog2(PARAM_EDGE_MEM_DEPTH):0] stat_edges,
    output logic [PARAM_COUNTER_WIDTH-1:0]        stat_max_fanout
`endif
);
    localparam int NODE_W = PARAM_NODE_IDX_WIDTH;
    localparam int CNT_W  = PARAM_COUNTER_WIDTH;
    localparam int DEPTH  = PARAM_EDGE_MEM_DEPTH;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int NODES  = 2 ** NODE_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [PTR_W:0]   EDGE_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOOKUP, STREAM} state_t;

    state_t            state_q, state_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    edge_ptr_q, edge_ptr_d;
    logic [NODE_W-1:0] prev_node_q, prev_node_d;
    logic              prev_valid_q, prev_valid_d;
    logic              load_err_q, load_err_d;

    logic [CNT_W-1:0]  count_q [NODES];
    logic [PTR_W-1:0]  offset_mem [NODES];
    logic [NODE_W-1:0] edge_mem [DEPTH];
    logic [NODE_W-1:0] rd_data_q;

    logic              load_fire;
    logic              edge_we;
    logic              offset_we;
    logic [CNT_W-1:0]  cur_count;
    logic [CNT_W-1:0]  new_count;
    logic [PTR_W-1:0]  rd_addr;
    logic              idle;

    assign idle         = (state_q == IDLE);
    assign bus.load_err = load_err_q;

    // A new CSR run starts whenever the source node changes; dropped edges leave the run untouched.
    always_comb begin
        load_fire    = bus.load_valid && idle && !bus.load_clear;
        cur_count    = count_q[bus.load_node];
        new_count    = cur_count + 1'b1;
        edge_we      = 1'b0;
        offset_we    = 1'b0;
        edge_ptr_d   = edge_ptr_q;
        prev_node_d  = prev_node_q;
        prev_valid_d = prev_valid_q;
        load_err_d   = load_err_q;
        if (bus.load_clear) begin
            edge_ptr_d   = '0;
            prev_valid_d = 1'b0;
            load_err_d   = 1'b0;
        end else if (load_fire) begin
            if (cur_count == CNT_MAX || edge_ptr_q == EDGE_FULL) begin
                load_err_d = 1'b1;
            end else begin
                edge_we      = 1'b1;
                offset_we    = !prev_valid_q || (prev_node_q != bus.load_node);
                edge_ptr_d   = edge_ptr_q + 1'b1;
                prev_node_d  = bus.load_node;
                prev_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) count_q[i] <= '0;
        end else if (bus.load_clear) begin
            for (int i = 0; i < NODES; i++) count_q[i] <= '0;
        end else if (edge_we) begin
            count_q[bus.load_node] <= new_count;
        end
    end

    always_ff @(posedge clk) begin
        if (edge_we) edge_mem[edge_ptr_q[PTR_W-1:0]] <= bus.load_succ;
        if (offset_we) offset_mem[bus.load_node] <= edge_ptr_q[PTR_W-1:0];
        rd_data_q <= edge_mem[rd_addr];
    end

    // The read address jumps ahead on a response handshake so the next entry lands without a gap.
    always_comb begin
        state_d               = state_q;
        node_d                = node_q;
        rem_d                 = rem_q;
        rd_ptr_d              = rd_ptr_q;
        rd_addr               = rd_ptr_q;
        bus.load_ready        = idle;
        bus.req_ready         = idle && !bus.load_valid;
        bus.resp_valid        = 1'b0;
        bus.next_node_idx     = '0;
        bus.next_node_counter = '0;
        bus.resp_last         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.load_valid) begin
                    node_d  = bus.node_idx_reg;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                rem_d    = count_q[node_q];
                rd_ptr_d = offset_mem[node_q];
                rd_addr  = offset_mem[node_q];
                state_d  = STREAM;
            end
            STREAM: begin
                bus.resp_valid = 1'b1;
                if (rem_q == '0) begin
                    bus.resp_last = 1'b1;
                end else begin
                    bus.next_node_idx     = rd_data_q;
                    bus.next_node_counter = rem_q;
                    bus.resp_last         = (rem_q == CNT_W'(1));
                end
                if (bus.resp_ready) begin
                    if (rem_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        rem_d    = rem_q - 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        rd_addr  = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            node_q       <= '0;
            rem_q        <= '0;
            rd_ptr_q     <= '0;
            edge_ptr_q   <= '0;
            prev_node_q  <= '0;
            prev_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            node_q       <= node_d;
            rem_q        <= rem_d;
            rd_ptr_q     <= rd_ptr_d;
            edge_ptr_q   <= edge_ptr_d;
            prev_node_q  <= prev_node_d;
            prev_valid_q <= prev_valid_d;
            load_err_q   <= load_err_d;
        end
    end

`ifdef ADJ_STATS_EN
    logic [PTR_W:0]   stat_edges_q, stat_edges_d;
    logic [CNT_W-1:0] stat_max_q, stat_max_d;

    always_comb begin
        stat_edges_d = stat_edges_q;
        stat_max_d   = stat_max_q;
        if (bus.load_clear) begin
            stat_edges_d = '0;
            stat_max_d   = '0;
        end else if (edge_we) begin
            stat_edges_d = stat_edges_q + 1'b1;
            if (new_count > stat_max_q) stat_max_d = new_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_edges_q <= '0;
            stat_max_q   <= '0;
        end else begin
            stat_edges_q <= stat_edges_d;
            stat_max_q   <= stat_max_d;
        end
    end

    assign stat_edges      = stat_edges_q;
    assign stat_max_fanout = stat_max_q;
`endif
endmodule

// File: tb/tb_graph_adj_responder.sv
// Directed bench for graph_adj_responder: an edge-list model predicts every response,
// and one negedge process compares the DUT stream against it.
module tb_graph_adj_responder;
    localparam int NW    = 10;
    localparam int CW    = 4;
    localparam int DEPTH = 2048;
    localparam int MAXF  = 15;

    typedef struct {
        int idx;
        int cnt;
        int last;
    } resp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int    mNode[$];
    int    mSucc[$];
    int    mErr;
    resp_t expQ[$];

    graph_adj_responder_if #(.NODE_W(NW), .CNT_W(CW)) bus ();

`ifdef ADJ_STATS_EN
    logic [$clog2(DEPTH):0] stat_edges;
    logic [CW-1:0]          stat_max_fanout;
`endif

    graph_adj_responder #(
        .PARAM_NODE_IDX_WIDTH(NW),
        .PARAM_COUNTER_WIDTH (CW),
        .PARAM_EDGE_MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ADJ_STATS_EN
        ,
        .stat_edges(stat_edges),
        .stat_max_fanout(stat_max_fanout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic failNow(string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic applyStimulus(int lv, int ln, int ls, int rv, int rn, int clr);
        bus.load_valid   = (lv != 0);
        bus.load_node    = NW'(ln);
        bus.load_succ    = NW'(ls);
        bus.req_valid    = (rv != 0);
        bus.node_idx_reg = NW'(rn);
        bus.load_clear   = (clr != 0);
    endtask

    function automatic int modelCount(int n);
        int c = 0;
        foreach (mNode[i]) if (mNode[i] == n) c++;
        return c;
    endfunction

    function automatic void modelLoad(int n, int s);
        if (modelCount(n) == MAXF || mNode.size() == DEPTH) begin
            mErr = 1;
        end else begin
            mNode.push_back(n);
            mSucc.push_back(s);
        end
    endfunction

    function automatic void modelClear();
        mNode.delete();
        mSucc.delete();
        mErr = 0;
    endfunction

    function automatic void modelExpect(int n);
        int succs[$];
        foreach (mNode[i]) if (mNode[i] == n) succs.push_back(mSucc[i]);
        if (succs.size() == 0) begin
            expQ.push_back('{0, 0, 1});
        end else begin
            foreach (succs[i])
                expQ.push_back('{succs[i], succs.size() - i, (i == succs.size() - 1) ? 1 : 0});
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedResp actual=valid expected=idle");
            end else begin
                checkOutput("respIdx", 32'(bus.next_node_idx), expQ[0].idx);
                checkOutput("respCnt", 32'(bus.next_node_counter), expQ[0].cnt);
                checkOutput("respLast", 32'(bus.resp_last), expQ[0].last);
                if (bus.resp_ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic loadEdge(int n, int s);
        applyStimulus(1, n, s, 0, 0, 0);
        @(negedge clk);
        checkOutput("loadReady", 32'(bus.load_ready), 1);
        @(posedge clk);
        modelLoad(n, s);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    // Returns at the negedge of cycle T+2, where the first response must be showing.
    task automatic startRequest(int n, output int waited);
        waited = 0;
        applyStimulus(0, 0, 0, 1, n, 0);
        @(negedge clk);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            failNow("reqReadyWait");
            applyStimulus(0, 0, 0, 0, 0, 0);
            return;
        end
        @(posedge clk);
        modelExpect(n);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lookupGap", 32'(bus.resp_valid), 0);
        @(negedge clk);
        checkOutput("firstValid", 32'(bus.resp_valid), 1);
        checkOutput("busyReqReady", 32'(bus.req_ready), 0);
    endtask

    task automatic drain(string name);
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (expQ.size() != 0) begin
            failNow({name, "Drain"});
            expQ.delete();
        end
        @(negedge clk);
        checkOutput({name, "ReqReady"}, 32'(bus.req_ready), 1);
        checkOutput({name, "Idle"}, 32'(bus.resp_valid), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        rst            = 1'b1;
        bus.resp_ready = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        modelClear();
        #2;
        checkOutput("rstLoadReady", 32'(bus.load_ready), 1);
        checkOutput("rstReqReady", 32'(bus.req_ready), 1);
        checkOutput("rstRespValid", 32'(bus.resp_valid), 0);
        checkOutput("rstLoadErr", 32'(bus.load_err), 0);
        checkOutput("rstIdx", 32'(bus.next_node_idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] node 5 -> {7,9,12}");
        loadEdge(5, 7);
        loadEdge(5, 9);
        loadEdge(5, 12);
        startRequest(5, w);
        checkOutput("n5FirstIdx", 32'(bus.next_node_idx), 7);
        checkOutput("n5FirstCnt", 32'(bus.next_node_counter), 3);
        checkOutput("n5FirstLast", 32'(bus.resp_last), 0);
        drain("n5");

        $display("[TB] unloaded node 100");
        startRequest(100, w);
        checkOutput("n100Idx", 32'(bus.next_node_idx), 0);
        checkOutput("n100Cnt", 32'(bus.next_node_counter), 0);
        checkOutput("n100Last", 32'(bus.resp_last), 1);
        drain("n100");

        $display("[TB] backpressure on node 5");
        startRequest(5, w);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("holdValid", 32'(bus.resp_valid), 1);
            checkOutput("holdIdx", 32'(bus.next_node_idx), 9);
            checkOutput("holdCnt", 32'(bus.next_node_counter), 2);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("resumeIdx", 32'(bus.next_node_idx), 12);
        checkOutput("resumeLast", 32'(bus.resp_last), 1);
        drain("hold");

        $display("[TB] fanout overflow on node 3");
        for (int i = 0; i < 15; i++) loadEdge(3, 100 + i);
        checkOutput("preOvfErr", 32'(bus.load_err), 0);
        loadEdge(3, 115);
        checkOutput("ovfErr", 32'(bus.load_err), 1);
        checkOutput("ovfErrModel", 32'(bus.load_err), mErr);
        startRequest(3, w);
        checkOutput("n3FirstIdx", 32'(bus.next_node_idx), 100);
        checkOutput("n3FirstCnt", 32'(bus.next_node_counter), 15);
        drain("n3");

        $display("[TB] same-cycle load and request");
        applyStimulus(1, 20, 21, 1, 20, 0);
        @(negedge clk);
        checkOutput("collideReqReady", 32'(bus.req_ready), 0);
        checkOutput("collideLoadReady", 32'(bus.load_ready), 1);
        @(posedge clk);
        modelLoad(20, 21);
        #1;
        startRequest(20, w);
        checkOutput("acceptNextCycle", w, 0);
        checkOutput("n20Idx", 32'(bus.next_node_idx), 21);
        checkOutput("n20Last", 32'(bus.resp_last), 1);
        drain("n20");

        $display("[TB] load_clear");
        checkOutput("errBeforeClear", 32'(bus.load_err), 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(posedge clk);
        modelClear();
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("clearErr", 32'(bus.load_err), 0);
        @(posedge clk);
        #1;
        startRequest(20, w);
        checkOutput("clearedCnt", 32'(bus.next_node_counter), 0);
        checkOutput("clearedLast", 32'(bus.resp_last), 1);
        drain("cleared");

        $display("[TB] reset mid-stream");
        loadEdge(5, 7);
        loadEdge(5, 9);
        loadEdge(5, 12);
        startRequest(5, w);
        @(posedge clk);
        #1;
        checkOutput("rstSecondIdx", 32'(bus.next_node_idx), 9);
        rst = 1'b1;
        #1;
        checkOutput("rstAbortValid", 32'(bus.resp_valid), 0);
        checkOutput("rstAbortReqReady", 32'(bus.req_ready), 1);
        expQ.delete();
        modelClear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        startRequest(5, w);
        checkOutput("postRstIdx", 32'(bus.next_node_idx), 0);
        checkOutput("postRstCnt", 32'(bus.next_node_counter), 0);
        checkOutput("postRstLast", 32'(bus.resp_last), 1);
        drain("postRst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
